// File: rtl/uart_pkg.sv
// Shared types for the UART transmitter: FSM state encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Controller-to-transmitter byte handshake plus serial line and Busy return.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
        output TX_OUT, Busy
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// Latched payload shifter and bit counter; o_ser_bit is always the next bit to emit.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_shift,
    input  logic                  i_adv,
    output logic                  o_ser_bit,
    output logic                  o_ser_done
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] r_sh;
    logic [CW-1:0]         r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sh  <= i_data;
            r_cnt <= '0;
        end else begin
            if (i_shift) r_sh <= r_sh >> 1;
            if (i_adv)   r_cnt <= r_cnt + 1'b1;
        end
    end

    // r_cnt is the index of the bit currently on the line
    assign o_ser_bit  = r_sh[0];
    assign o_ser_done = (r_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           RST,
    uart_tx_frame_if.slave bus
);

    state_t r_state;
    state_t w_nxt;
    logic   r_tx;
    logic   r_busy;
    logic   r_pen;
    logic   r_par;
    logic   w_tx_nxt;
    logic   w_load;
    logic   w_shift;
    logic   w_adv;
    logic   w_ser_bit;
    logic   w_ser_done;
`ifdef UART_TX_TWO_STOP_EN
    logic   r_stop2;
`endif

    uart_tx_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst_n     (RST),
        .i_load    (w_load),
        .i_data    (bus.P_DATA),
        .i_shift   (w_shift),
        .i_adv     (w_adv),
        .o_ser_bit (w_ser_bit),
        .o_ser_done(w_ser_done)
    );

    // Outputs are registered from the next state, so they track r_state exactly
    always_comb begin
        w_nxt    = r_state;
        w_tx_nxt = IDLE_LVL;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_adv    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.Data_Valid) begin
                    w_nxt    = START;
                    w_load   = 1'b1;
                    w_tx_nxt = START_LVL;
                end
            end
            START: begin
                w_nxt    = DATA;
                w_shift  = 1'b1;
                w_tx_nxt = w_ser_bit;
            end
            DATA: begin
                if (w_ser_done) begin
                    if (r_pen) begin
                        w_nxt    = PARITY;
                        w_tx_nxt = r_par;
                    end else begin
                        w_nxt = STOP;
                    end
                end else begin
                    w_shift  = 1'b1;
                    w_adv    = 1'b1;
                    w_tx_nxt = w_ser_bit;
                end
            end
            PARITY: w_nxt = STOP;
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                w_nxt = r_stop2 ? IDLE : STOP;
`else
                w_nxt = IDLE;
`endif
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_tx    <= IDLE_LVL;
            r_busy  <= 1'b0;
            r_pen   <= 1'b0;
            r_par   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_nxt != IDLE);
            if (w_load) begin
                r_pen <= bus.PAR_EN;
                r_par <= (^bus.P_DATA) ^ bus.PAR_TYP;
            end
        end
    end

`ifdef UART_TX_TWO_STOP_EN
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_stop2 <= 1'b0;
        else      r_stop2 <= (r_state == STOP) && !r_stop2;
    end
`endif

    assign bus.TX_OUT = r_tx;
    assign bus.Busy   = r_busy;

endmodule
